// File: rtl/stereo_matrix_gain.sv
// Stereo matrix and gain stage: captures an L/R pair, forms the half-sum and
// half-difference, and scales each through one shared LSB-first shift-add multiplier.
module stereo_matrix_gain #(
  parameter int DW   = 18,
  parameter int KW   = 4,
  parameter int FRAC = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clken_in,
  input  logic [DW-1:0] left,
  input  logic [DW-1:0] right,
  input  logic [KW-1:0] ks,
  input  logic [KW-1:0] kd,
  output logic [DW-1:0] lpr_out,
  output logic [DW-1:0] lmr_out,
  output logic          out_valid,
  output logic          busy,
  output logic          overrun
);

  localparam int PW = DW + KW + 1;
  localparam int CW = (KW > 1) ? $clog2(KW) : 1;

  localparam logic signed [PW-1:0] MAX_VAL = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_VAL = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL_S, MUL_D, DONE} state_t;

  state_t                state_reg, state_next;
  logic signed [DW-1:0]  left_reg, right_reg;
  logic [KW-1:0]         ks_reg, kd_reg;
  logic [CW-1:0]         cnt_reg;
  logic signed [PW-1:0]  acc_reg;
  logic signed [PW-1:0]  prod_s_reg;
  logic [DW-1:0]         lpr_reg, lmr_reg;
  logic                  valid_reg, overrun_reg;

  logic signed [DW:0]    sum_w, dif_w, s_w, d_w, operand;
  logic signed [PW-1:0]  op_ext, partial, acc_base, acc_sum;
  logic                  gain_bit, last_bit;

  // Matrix at DW+1 bits; the floor halving always brings the result back into DW bits.
  always_comb begin
    sum_w    = {left_reg[DW-1], left_reg} + {right_reg[DW-1], right_reg};
    dif_w    = {left_reg[DW-1], left_reg} - {right_reg[DW-1], right_reg};
    s_w      = sum_w >>> 1;
    d_w      = dif_w >>> 1;
    operand  = (state_reg == MUL_D) ? d_w : s_w;
    gain_bit = (state_reg == MUL_D) ? kd_reg[cnt_reg] : ks_reg[cnt_reg];
    op_ext   = {{(PW-DW-1){operand[DW]}}, operand};
    partial  = gain_bit ? (op_ext <<< cnt_reg) : '0;
    acc_base = (cnt_reg == '0) ? '0 : acc_reg;
    acc_sum  = acc_base + partial;
    last_bit = (cnt_reg == CW'(KW - 1));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (clken_in) state_next = MUL_S;
      MUL_S:   if (last_bit) state_next = MUL_D;
      MUL_D:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  function automatic logic [DW-1:0] shift_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] r;
    r = p >>> FRAC;
    if (r > MAX_VAL)      r = MAX_VAL;
    else if (r < MIN_VAL) r = MIN_VAL;
    return r[DW-1:0];
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      left_reg    <= '0;
      right_reg   <= '0;
      ks_reg      <= '0;
      kd_reg      <= '0;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      prod_s_reg  <= '0;
      lpr_reg     <= '0;
      lmr_reg     <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      valid_reg <= (state_reg == DONE);
      if (clken_in && state_reg != IDLE) overrun_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (clken_in) begin
            left_reg  <= left;
            right_reg <= right;
            ks_reg    <= ks;
            kd_reg    <= kd;
            cnt_reg   <= '0;
          end
        end
        MUL_S, MUL_D: begin
          acc_reg <= acc_sum;
          cnt_reg <= last_bit ? '0 : cnt_reg + CW'(1);
          // Park the sum product so the accumulator can be reused for the difference.
          if (state_reg == MUL_S && last_bit) prod_s_reg <= acc_sum;
        end
        DONE: begin
          lpr_reg <= shift_sat(prod_s_reg);
          lmr_reg <= shift_sat(acc_reg);
        end
        default: ;
      endcase
    end
  end

  assign lpr_out   = lpr_reg;
  assign lmr_out   = lmr_reg;
  assign out_valid = valid_reg;
  assign busy      = (state_reg != IDLE);
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_stereo_matrix_gain.sv
// Self-checking bench for stereo_matrix_gain: directed corner cases plus randomized
// transactions checked against an integer reference model.
module tb_stereo_matrix_gain;

  localparam int DW   = 18;
  localparam int KW   = 4;
  localparam int FRAC = 3;
  localparam int LAT  = 2 * KW + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          clken_in;
  logic [DW-1:0] left, right;
  logic [KW-1:0] ks, kd;
  logic [DW-1:0] lpr_out, lmr_out;
  logic          out_valid, busy, overrun;

  int n_checks = 0;
  int n_errors = 0;

  stereo_matrix_gain #(.DW(DW), .KW(KW), .FRAC(FRAC)) dut (
    .clock(clock), .reset(reset), .clken_in(clken_in),
    .left(left), .right(right), .ks(ks), .kd(kd),
    .lpr_out(lpr_out), .lmr_out(lmr_out),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: floor-halved matrix, integer gain, floor shift, clamp to DW bits.
  function automatic int model(input int a, input int b, input int g, input bit diff);
    longint m, p, q;
    longint hi, lo;
    m  = diff ? longint'(a) - b : longint'(a) + b;
    p  = (m >>> 1) * g;
    q  = p >>> FRAC;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -(longint'(1) <<< (DW - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return int'(q);
  endfunction

  function automatic int rand_sample();
    logic [DW-1:0] t;
    case ($urandom_range(0, 5))
      0:       t = {1'b0, {(DW-1){1'b1}}};
      1:       t = {1'b1, {(DW-1){1'b0}}};
      default: t = DW'($urandom);
    endcase
    return int'($signed(t));
  endfunction

  // Starts at a negedge with the DUT idle; returns at the negedge of the out_valid cycle.
  task automatic run_txn(input string name, input int l, input int r, input int gs, input int gd,
                         input bit perturb, input int extra_at);
    int busy_cnt, v_idx;
    left = DW'(l); right = DW'(r); ks = KW'(gs); kd = KW'(gd);
    clken_in = 1'b1;
    @(negedge clock);
    clken_in = 1'b0;
    busy_cnt = 0;
    v_idx    = -1;
    for (int k = 0; k < LAT + 6; k++) begin
      if (out_valid) begin
        v_idx = k;
        break;
      end
      if (busy) busy_cnt++;
      clken_in = (k == extra_at);
      if (clken_in || (perturb && busy)) begin
        left = DW'($urandom); right = DW'($urandom);
        ks = KW'($urandom); kd = KW'($urandom);
      end
      @(negedge clock);
    end
    clken_in = 1'b0;
    check({name, " latency"}, v_idx, LAT);
    check({name, " busy_cycles"}, busy_cnt, LAT);
    check({name, " busy_in_valid"}, busy, 0);
    check({name, " lpr"}, int'($signed(lpr_out)), model(l, r, gs, 1'b0));
    check({name, " lmr"}, int'($signed(lmr_out)), model(l, r, gd, 1'b1));
    $display("txn %-10s L=%0d R=%0d ks=%0d kd=%0d -> lpr=%0d lmr=%0d ovr=%0b",
             name, l, r, gs, gd, $signed(lpr_out), $signed(lmr_out), overrun);
  endtask

  initial begin
    int vcnt;
    reset = 1'b1; clken_in = 1'b0;
    left = '0; right = '0; ks = '0; kd = '0;
    repeat (3) @(negedge clock);
    check("rst lpr", lpr_out, 0);
    check("rst lmr", lmr_out, 0);
    check("rst valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst overrun", overrun, 0);
    reset = 1'b0;
    @(negedge clock);

    run_txn("basic", 1000, 200, 8, 8, 1'b0, -1);
    check("basic overrun", overrun, 0);
    run_txn("floor", -5, 0, 1, 1, 1'b0, -1);
    run_txn("sat_pos", 131071, 131071, 15, 15, 1'b0, -1);
    run_txn("sat_neg", -131072, 131071, 15, 15, 1'b0, -1);
    run_txn("gain0", 77777, -1234, 0, 0, 1'b0, -1);

    // Second enable sampled at E4 must be dropped and flag overrun.
    run_txn("overrun", 4000, -3000, 5, 9, 1'b0, 3);
    check("overrun set", overrun, 1);
    vcnt = 0;
    repeat (2) begin
      @(negedge clock);
      if (out_valid) vcnt++;
      check("overrun idle", busy, 0);
    end
    check("overrun extra_valid", vcnt, 0);
    run_txn("after_ovr", -60000, 25000, 12, 3, 1'b0, -1);
    check("overrun sticky", overrun, 1);

    // Reset sampled at E5 aborts the computation.
    left = DW'(50000); right = DW'(-7); ks = 4'd9; kd = 4'd11;
    clken_in = 1'b1;
    @(negedge clock);
    clken_in = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst lpr", lpr_out, 0);
    check("midrst lmr", lmr_out, 0);
    check("midrst busy", busy, 0);
    check("midrst overrun", overrun, 0);
    vcnt = 0;
    for (int k = 0; k < LAT + 3; k++) begin
      if (out_valid) vcnt++;
      @(negedge clock);
    end
    check("midrst no_valid", vcnt, 0);
    run_txn("post_rst", 12345, -54321, 7, 13, 1'b1, -1);

    // Back-to-back randomized transactions with inputs churning while busy.
    for (int i = 0; i < 30; i++) begin
      run_txn("rand", rand_sample(), rand_sample(), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), 1'b1, -1);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clock);
    end
    check("final overrun", overrun, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
